dbg_master: RTL and testbench

DBG_MASTER -- requirements
Module: dbg_master

---
 rtl/dbg_master_pkg.sv | 18 +
 rtl/dbg_master.sv | 137 +++++++++++++
 tb/tb_dbg_master.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_master_pkg.sv
// Shared types and byte constants for the serial debug bus master.
package dbg_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

endpackage

// File: rtl/dbg_master.sv
// Byte-stream command decoder driving one word access on a valid/ready bus.
module dbg_master
  import dbg_master_pkg::*;
#(
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state;
  state_t          nxt;
  logic            op_wr;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [1:0]      byte_cnt;
  logic [CW-1:0]   idle_cnt;
  logic            tx_fire;
  logic            tmo;
  logic [31:0]     addr_nxt;

  assign mem_instr = 1'b0;
  assign mem_addr  = addr;
  assign mem_wdata = wdata;

  always_comb begin
    nxt       = state;
    tx_fire   = tx_valid && tx_ready;
    tmo       = (idle_cnt == CW'(TIMEOUT - 1));
    addr_nxt  = {rx_data, addr[31:8]};
    busy      = (state != S_IDLE);
    mem_valid = (state == S_BUS);
    mem_wstrb = (state == S_BUS && op_wr) ? 4'hF : 4'h0;
    tx_valid  = (state == S_RESP) || (state == S_ERR);
    tx_data   = 8'h00;
    unique case (state)
      S_IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            rx_data == OP_WR: nxt = S_ADDR;
            rx_data == OP_RD: nxt = S_ADDR;
            default:          nxt = S_ERR;
          endcase
        end
      end
      S_ADDR: begin
        if (rx_valid && byte_cnt == 2'd3) begin
          // the first byte lands in addr_nxt[7:0]
          if (addr_nxt[1:0] != 2'b00) nxt = S_ERR;
          else if (op_wr)             nxt = S_DATA;
          else                        nxt = S_BUS;
        end else if (!rx_valid && tmo) begin
          nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid && byte_cnt == 2'd3) nxt = S_BUS;
        else if (!rx_valid && tmo)        nxt = S_IDLE;
      end
      S_BUS: begin
        if (mem_ready) nxt = S_RESP;
      end
      S_RESP: begin
        tx_data = op_wr ? RSP_OK : rdata[{byte_cnt, 3'b000} +: 8];
        if (tx_fire && (op_wr || byte_cnt == 2'd3)) nxt = S_IDLE;
      end
      S_ERR: begin
        tx_data = RSP_ERR;
        if (tx_fire) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      op_wr    <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      rdata    <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: begin
          byte_cnt <= '0;
          idle_cnt <= '0;
          if (rx_valid) op_wr <= (rx_data == OP_WR);
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr     <= addr_nxt;
            byte_cnt <= byte_cnt + 2'd1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            wdata    <= {rx_data, wdata[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + CW'(1);
          end
        end
        S_BUS: begin
          if (mem_ready && !op_wr) rdata <= mem_rdata;
        end
        S_RESP: begin
          if (tx_fire) byte_cnt <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_master.sv
// Scoreboard bench for dbg_master: queued bus and tx expectations.
module tb_dbg_master;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          cyc;
  } mexp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int mem_delay = 1;
  int tx_stall = 0;
  logic [31:0] rd_val = 32'h0;

  mexp_t      mq[$];
  logic [7:0] tq[$];

  dbg_master #(.TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // bus responder: ready after mem_delay extra valid cycles
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      if (!mem_valid) cnt = 0;
      else begin
        cnt++;
        if (cnt > mem_delay) begin
          mem_ready = 1'b1;
          mem_rdata = rd_val;
          cnt = 0;
        end
      end
    end
  end

  // tx consumer: ready after tx_stall cycles per byte
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      tx_ready = 1'b0;
      if (!tx_valid) cnt = 0;
      else begin
        cnt++;
        if (cnt > tx_stall) begin
          tx_ready = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  // monitor on the falling edge
  initial begin
    int mcyc = 0;
    forever begin
      @(negedge clk);
      if (!mem_valid) mcyc = 0;
      if (rst) begin
        if (mem_valid) begin
          mcyc++;
          if (mq.size() == 0) chk("mem_unexp", 32'(mem_valid), 32'd0);
          else begin
            chk("mem_addr", mem_addr, mq[0].a);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(mq[0].s));
            chk("mem_instr", 32'(mem_instr), 32'd0);
            if (mq[0].s != 4'h0) chk("mem_wdata", mem_wdata, mq[0].d);
            if (mem_ready) begin
              chk("mem_cycles", 32'(mcyc), 32'(mq[0].cyc));
              void'(mq.pop_front());
            end
          end
        end
        if (tx_valid) begin
          if (tq.size() == 0) chk("tx_unexp", 32'(tx_data), 32'hFFFF);
          else begin
            chk("tx_data", 32'(tx_data), 32'(tq[0]));
            if (tx_ready) void'(tq.pop_front());
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_mem(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    mexp_t e;
    e.a = a;
    e.d = d;
    e.s = s;
    e.cyc = mem_delay + 1;
    mq.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tq.push_back(w[8*i +: 8]);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((busy || mq.size() != 0 || tq.size() != 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_bound"}, 32'(n < 2000), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // write
    mem_delay = 1;
    push_mem(32'h0, 32'hDEADBEEF, 4'hF);
    tq.push_back(8'h4B);
    send_byte(8'h57);
    send_word(32'h0);
    send_word(32'hDEADBEEF);
    wait_done("wr");

    // read
    rd_val = 32'h12345678;
    push_mem(32'h10, 32'h0, 4'h0);
    push_rd(rd_val);
    send_byte(8'h52);
    send_word(32'h10);
    wait_done("rd");

    // bad opcode and misaligned address
    tq.push_back(8'h45);
    send_byte(8'h41);
    wait_done("badop");
    tq.push_back(8'h45);
    send_byte(8'h52);
    send_word(32'h3);
    wait_done("misal");

    // inter-byte timeout, then a normal read
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo_before", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("tmo_after", 32'(busy), 32'd0);
    rd_val = 32'hCAFEF00D;
    push_mem(32'h20, 32'h0, 4'h0);
    push_rd(rd_val);
    send_byte(8'h52);
    send_word(32'h20);
    wait_done("tmo_rd");

    // backpressure on both sides, stray rx byte during the bus phase
    mem_delay = 10;
    tx_stall = 5;
    rd_val = 32'hA5A55A5A;
    push_mem(32'h100, 32'h0, 4'h0);
    push_rd(rd_val);
    send_byte(8'h52);
    send_word(32'h100);
    chk("bus_state", 32'(mem_valid), 32'd1);
    send_byte(8'h41);
    wait_done("bp");
    tx_stall = 0;

    // reset while the bus request is pending
    mem_delay = 1000;
    push_mem(32'h40, 32'h0, 4'h0);
    send_byte(8'h52);
    send_word(32'h40);
    repeat (3) @(posedge clk);
    #1;
    chk("midbus_valid", 32'(mem_valid), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(mem_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx", 32'(tx_valid), 32'd0);
    mq.delete();
    rst = 1'b1;
    @(posedge clk); #1;

    // recovery write
    mem_delay = 0;
    push_mem(32'h80, 32'h01020304, 4'hF);
    tq.push_back(8'h4B);
    send_byte(8'h57);
    send_word(32'h80);
    send_word(32'h01020304);
    wait_done("rec");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
